nios_debug_slave_sysclk_sync: RTL and testbench

- Parametrised successor to the Nios II debug-slave system-clock half.
- Takes the virtual-JTAG update-IR and update-DR events, which arrive asynchronously from the TCK domain, into clk through a synchroniser of configurable depth.
- Captures the IR and the shift register, then decodes them into per-IR take_action / take_no_action strobes for any IR width.
- Adds an event counter and a sticky "DR update without IR" error flag, neither of which the fixed-width version has.

---
 rtl/nios_debug_slave_sysclk_sync.sv | 117 +++++++++++
 tb/tb_nios_debug_slave_sysclk_sync.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/nios_debug_slave_sysclk_sync.sv
// System-clock half of the Nios II debug slave: brings the TCK-domain
// update-IR / update-DR events into clk, captures IR and the shift register,
// and decodes them into per-IR action strobes. Also keeps a saturating count
// of DR updates and a sticky flag for a DR update seen before any IR update.
module nios_debug_slave_sysclk_sync #(
  parameter int unsigned SR_WIDTH    = 38,
  parameter int unsigned IR_WIDTH    = 2,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned ACTION_BIT  = 35,
  parameter int unsigned CNT_WIDTH   = 8
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       vs_uir,
  input  logic                       vs_udr,
  input  logic [IR_WIDTH-1:0]        ir_in,
  input  logic [SR_WIDTH-1:0]        sr,
  input  logic                       err_clr,
  output logic [SR_WIDTH-1:0]        jdo,
  output logic [IR_WIDTH-1:0]        ir_reg,
  output logic                       ir_valid,
  output logic [(2**IR_WIDTH)-1:0]   take_action,
  output logic [(2**IR_WIDTH)-1:0]   take_no_action,
  output logic [CNT_WIDTH-1:0]       udr_count,
  output logic                       no_ir_err
);

  localparam int unsigned NUM_IR = 2**IR_WIDTH;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic [SYNC_STAGES-1:0] uir_sync;
  logic [SYNC_STAGES-1:0] udr_sync;
  logic                   uir_dly;
  logic                   udr_dly;
  logic                   uir_pulse;
  logic                   udr_pulse;
  logic                   strobe_q;

  // Synchroniser chains plus one delay flop each for rising-edge detection
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      uir_sync <= '0;
      udr_sync <= '0;
      uir_dly  <= 1'b0;
      udr_dly  <= 1'b0;
    end else begin
      uir_sync <= {uir_sync[SYNC_STAGES-2:0], vs_uir};
      udr_sync <= {udr_sync[SYNC_STAGES-2:0], vs_udr};
      uir_dly  <= uir_sync[SYNC_STAGES-1];
      udr_dly  <= udr_sync[SYNC_STAGES-1];
    end
  end

  // One-cycle pulse per synchronised rising edge
  always_comb begin
    uir_pulse = uir_sync[SYNC_STAGES-1] & ~uir_dly;
    udr_pulse = udr_sync[SYNC_STAGES-1] & ~udr_dly;
  end

  // IR capture; ir_valid stays set until reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ir_reg   <= '0;
      ir_valid <= 1'b0;
    end else if (uir_pulse) begin
      ir_reg   <= ir_in;
      ir_valid <= 1'b1;
    end
  end

  // DR capture and single-cycle strobe that drives the decode
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      jdo      <= '0;
      strobe_q <= 1'b0;
    end else begin
      strobe_q <= udr_pulse;
      if (udr_pulse) begin
        jdo <= sr;
      end
    end
  end

  // Saturating DR-update counter
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      udr_count <= '0;
    end else if (udr_pulse && (udr_count != CNT_MAX)) begin
      udr_count <= udr_count + CNT_WIDTH'(1);
    end
  end

  // Sticky error: DR update with no IR ever captured (a same-edge IR update counts)
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      no_ir_err <= 1'b0;
    end else if (udr_pulse && !ir_valid && !uir_pulse) begin
      no_ir_err <= 1'b1;
    end else if (err_clr) begin
      no_ir_err <= 1'b0;
    end
  end

  // Decode the strobe into a one-hot action / no-action vector by IR
  always_comb begin
    take_action    = '0;
    take_no_action = '0;
    if (strobe_q) begin
      if (jdo[ACTION_BIT]) begin
        take_action    = NUM_IR'(1) << ir_reg;
      end else begin
        take_no_action = NUM_IR'(1) << ir_reg;
      end
    end
  end

endmodule

// File: tb/tb_nios_debug_slave_sysclk_sync.sv
// Bench for nios_debug_slave_sysclk_sync: directed stimulus, a delay-line
// model of the event path, a per-cycle comparator and literal spot checks.
module tb_nios_debug_slave_sysclk_sync;

  localparam int S = 2;

  logic        clk;
  logic        reset_n;
  logic        vs_uir;
  logic        vs_udr;
  logic [1:0]  ir_in;
  logic [37:0] sr;
  logic        err_clr;

  logic [37:0] jdo_a,  jdo_b;
  logic [1:0]  ir_a,   ir_b;
  logic        irv_a,  irv_b;
  logic [3:0]  ta_a,   ta_b;
  logic [3:0]  tna_a,  tna_b;
  logic [7:0]  cnt_a;
  logic [2:0]  cnt_b;
  logic        err_a,  err_b;

  nios_debug_slave_sysclk_sync dut (
    .clk(clk), .reset_n(reset_n), .vs_uir(vs_uir), .vs_udr(vs_udr),
    .ir_in(ir_in), .sr(sr), .err_clr(err_clr),
    .jdo(jdo_a), .ir_reg(ir_a), .ir_valid(irv_a),
    .take_action(ta_a), .take_no_action(tna_a),
    .udr_count(cnt_a), .no_ir_err(err_a)
  );

  nios_debug_slave_sysclk_sync #(.CNT_WIDTH(3)) dut3 (
    .clk(clk), .reset_n(reset_n), .vs_uir(vs_uir), .vs_udr(vs_udr),
    .ir_in(ir_in), .sr(sr), .err_clr(err_clr),
    .jdo(jdo_b), .ir_reg(ir_b), .ir_valid(irv_b),
    .take_action(ta_b), .take_no_action(tna_b),
    .udr_count(cnt_b), .no_ir_err(err_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int strobes3 = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  // Input histories indexed by edge number; a level sampled at edge k becomes
  // visible to the edge detector S edges later, unless a reset edge intervened.
  logic uh [0:8191];
  logic dh [0:8191];
  int   e = -1;
  int   last_rst = -1;
  bit   started = 0;

  logic [1:0]  m_ir;
  logic        m_valid;
  logic [37:0] m_jdo;
  logic        m_strobe;
  int          m_cnt;
  logic        m_err;

  function automatic logic seen(input bit is_udr, input int edge_no, input int lag);
    if (edge_no - lag > last_rst && edge_no - lag >= 0)
      return is_udr ? dh[edge_no - lag] : uh[edge_no - lag];
    return 1'b0;
  endfunction

  always @(posedge clk) begin
    logic up, dp;
    e = e + 1;
    uh[e] = vs_uir;
    dh[e] = vs_udr;
    if (!reset_n) begin
      last_rst = e;
      started  = 1;
      m_ir = '0; m_valid = 0; m_jdo = '0; m_strobe = 0; m_cnt = 0; m_err = 0;
    end else begin
      up = seen(0, e, S) & ~seen(0, e, S + 1);
      dp = seen(1, e, S) & ~seen(1, e, S + 1);
      if (dp && !m_valid && !up) m_err = 1;
      else if (err_clr) m_err = 0;
      if (up) begin m_ir = ir_in; m_valid = 1; end
      m_strobe = dp;
      if (dp) begin m_jdo = sr; m_cnt = m_cnt + 1; end
    end
  end

  // ---------------- per-cycle comparator ----------------
  always @(negedge clk) begin
    logic [3:0] exp_ta, exp_tna;
    if (started) begin
      exp_ta  = (m_strobe &&  m_jdo[35]) ? (4'b0001 << m_ir) : 4'b0000;
      exp_tna = (m_strobe && !m_jdo[35]) ? (4'b0001 << m_ir) : 4'b0000;
      chk("jdo",        64'(jdo_a), 64'(m_jdo));
      chk("ir_reg",     64'(ir_a),  64'(m_ir));
      chk("ir_valid",   64'(irv_a), 64'(m_valid));
      chk("take_act",   64'(ta_a),  64'(exp_ta));
      chk("take_noact", 64'(tna_a), 64'(exp_tna));
      chk("udr_count",  64'(cnt_a), 64'((m_cnt > 255) ? 255 : m_cnt));
      chk("no_ir_err",  64'(err_a), 64'(m_err));
      chk("c3_take",    64'({ta_b, tna_b}), 64'({exp_ta, exp_tna}));
      chk("c3_count",   64'(cnt_b), 64'((m_cnt > 7) ? 7 : m_cnt));
      chk("c3_err",     64'(err_b), 64'(m_err));
      if (|{ta_b, tna_b}) strobes3++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic steps(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    steps(2);
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0; vs_uir = 0; vs_udr = 0; ir_in = 2'b00; sr = '0; err_clr = 0;
    steps(3);
    reset_n = 1'b1;
    steps(2);
    #3 chk("rst_ir_valid", 64'(irv_a), 64'(0));
    chk("rst_strobes", 64'({ta_a, tna_a}), 64'(0));

    // Test 1: IR 1, action bit set
    ir_in = 2'b01; vs_uir = 1;
    steps(3);
    #3 chk("t1_ir_valid", 64'(irv_a), 64'(1));
    chk("t1_ir_reg", 64'(ir_a), 64'(1));
    steps(1); vs_uir = 0;
    steps(3);
    sr = 38'h2A_1234_5678; vs_udr = 1;
    steps(2);
    #3 chk("t1_pre_strobe", 64'(ta_a), 64'(0));
    steps(1);
    #3 chk("t1_take_action", 64'(ta_a), 64'(4'b0010));
    chk("t1_jdo", 64'(jdo_a), 64'(38'h2A_1234_5678));
    chk("t1_count", 64'(cnt_a), 64'(1));
    steps(1);
    #3 chk("t1_post_strobe", 64'(ta_a), 64'(0));
    vs_udr = 0;
    steps(4);

    // Test 2: IR 0, action bit clear
    ir_in = 2'b00; vs_uir = 1;
    steps(4); vs_uir = 0;
    steps(3);
    sr = 38'h05_0000_00AB; vs_udr = 1;
    steps(3);
    #3 chk("t2_take_noact", 64'(tna_a), 64'(4'b0001));
    chk("t2_take_action", 64'(ta_a), 64'(0));
    steps(1); vs_udr = 0;
    steps(4);

    // Test 3: DR update without IR, clear, then clear coincident with set
    do_reset();
    steps(2);
    vs_udr = 1;
    steps(3);
    #3 chk("t3_err_set", 64'(err_a), 64'(1));
    chk("t3_strobe_ir0", 64'(tna_a), 64'(4'b0001));
    steps(1); vs_udr = 0;
    steps(2);
    err_clr = 1;
    steps(1);
    #3 chk("t3_err_clr", 64'(err_a), 64'(0));
    err_clr = 0;
    steps(2);
    vs_udr = 1;
    steps(2);
    err_clr = 1;
    steps(1);
    #3 chk("t3_set_wins", 64'(err_a), 64'(1));
    err_clr = 0;
    steps(1); vs_udr = 0;
    steps(4);

    // Test 4: nine DR updates, 4 cycles apart
    do_reset();
    steps(2);
    strobes3 = 0;
    for (int i = 0; i < 9; i++) begin
      vs_udr = 1; steps(2);
      vs_udr = 0; steps(2);
    end
    steps(5);
    #3 chk("t4_count3_sat", 64'(cnt_b), 64'(7));
    chk("t4_count8", 64'(cnt_a), 64'(9));
    chk("t4_strobes", 64'(strobes3), 64'(9));

    // Test 5: simultaneous IR and DR updates
    do_reset();
    steps(2);
    ir_in = 2'b11; sr = 38'h3F_FFFF_0000; vs_uir = 1; vs_udr = 1;
    steps(3);
    #3 chk("t5_take_action", 64'(ta_a), 64'(4'b1000));
    chk("t5_no_err", 64'(err_a), 64'(0));
    chk("t5_ir_valid", 64'(irv_a), 64'(1));
    steps(1); vs_uir = 0; vs_udr = 0;
    steps(4);

    // Test 6: reset during the pulse cycle with vs_udr held high
    vs_udr = 1;
    steps(2);
    reset_n = 0;
    steps(1);
    #3 chk("t6_in_reset", 64'({ta_a, tna_a}), 64'(0));
    reset_n = 1;
    steps(1);
    #3 chk("t6_rel1", 64'({ta_a, tna_a}), 64'(0));
    steps(1);
    #3 chk("t6_rel2", 64'({ta_a, tna_a}), 64'(0));
    steps(1);
    #3 chk("t6_restrobe", 64'(ta_a), 64'(4'b0001));
    steps(1); vs_udr = 0;
    steps(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
